// File: rtl/pattern_decode.sv
// pattern_decode: receive-side rate-pattern checker. Counts the ones in a serial
// M-bit frame and compares it to the regenerated even-spread pattern for (M, N).
// Optional macro PATDEC_ERRPOS_EN adds first_err_pos / err_cnt outputs.
module pattern_decode #(
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] M,
    input  logic             bit_vld,
    input  logic             bit_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] n_out,
    output logic             match,
    output logic             err_len
`ifdef PATDEC_ERRPOS_EN
    ,
    output logic [CNT_W-1:0] first_err_pos,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int unsigned      PW    = 2 * CNT_W;
    localparam int unsigned      IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] MAX_M = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   c_q, c_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   i_q, i_d;
    logic [MAX_LEN-1:0] sr_q, sr_d;
    logic               ok_q, ok_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   n_out_q, n_out_d;
    logic               match_q, match_d;
    logic               err_len_q, err_len_d;
`ifdef PATDEC_ERRPOS_EN
    logic [CNT_W-1:0]   fe_q, fe_d;
    logic               fe_vld_q, fe_vld_d;
    logic [CNT_W-1:0]   ecnt_q, ecnt_d;
    logic [CNT_W-1:0]   first_err_pos_q, first_err_pos_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
`endif

    logic [IDX_W-1:0]   sr_idx;
    logic [PW-1:0]      lo, mid, hi;
    logic               exp_bit;
    logic               last_pos;

    // Position k lives at sr[MAX_LEN-1-k] so the first received bit is the MSB.
    assign sr_idx   = IDX_W'(MAX_LEN - 1) - IDX_W'(k_q);
    assign last_pos = ((k_q + ONE) == m_q);

    // Position k expects a one when i*M falls in [k*N, (k+1)*N); full-width products.
    assign lo      = PW'(k_q) * PW'(c_q);
    assign hi      = lo + PW'(c_q);
    assign mid     = PW'(i_q) * PW'(m_q);
    assign exp_bit = (lo <= mid) && (mid < hi);

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        c_d       = c_q;
        k_d       = k_q;
        i_d       = i_q;
        sr_d      = sr_q;
        ok_d      = ok_q;
        err_d     = err_q;
        done_d    = 1'b0;
        n_out_d   = n_out_q;
        match_d   = match_q;
        err_len_d = err_len_q;
`ifdef PATDEC_ERRPOS_EN
        fe_d            = fe_q;
        fe_vld_d        = fe_vld_q;
        ecnt_d          = ecnt_q;
        first_err_pos_d = first_err_pos_q;
        err_cnt_d       = err_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d       = M;
                    c_d       = '0;
                    k_d       = '0;
                    i_d       = '0;
                    sr_d      = '0;
                    ok_d      = 1'b1;
                    n_out_d   = '0;
                    match_d   = 1'b0;
                    err_len_d = 1'b0;
`ifdef PATDEC_ERRPOS_EN
                    fe_d            = '0;
                    fe_vld_d        = 1'b0;
                    ecnt_d          = '0;
                    first_err_pos_d = '0;
                    err_cnt_d       = '0;
`endif
                    if ((M == '0) || (M > MAX_M)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bit_vld) begin
                    sr_d[sr_idx] = bit_in;
                    c_d          = c_q + CNT_W'(bit_in);
                    if (last_pos) begin
                        k_d     = '0;
                        state_d = CHECK;
                    end else begin
                        k_d = k_q + ONE;
                    end
                end
            end
            CHECK: begin
                if (exp_bit != sr_q[sr_idx]) begin
                    ok_d = 1'b0;
`ifdef PATDEC_ERRPOS_EN
                    if (!fe_vld_q) begin
                        fe_d     = k_q;
                        fe_vld_d = 1'b1;
                    end
                    if (ecnt_q != '1) begin
                        ecnt_d = ecnt_q + ONE;
                    end
`endif
                end
                if (exp_bit) begin
                    i_d = i_q + ONE;
                end
                if (last_pos) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + ONE;
                end
            end
            DONE: begin
                done_d    = 1'b1;
                n_out_d   = c_q;
                match_d   = ok_q & ~err_q;
                err_len_d = err_q;
`ifdef PATDEC_ERRPOS_EN
                first_err_pos_d = fe_vld_q ? fe_q : '1;
                err_cnt_d       = ecnt_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            i_q       <= '0;
            sr_q      <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            n_out_q   <= '0;
            match_q   <= 1'b0;
            err_len_q <= 1'b0;
`ifdef PATDEC_ERRPOS_EN
            fe_q            <= '0;
            fe_vld_q        <= 1'b0;
            ecnt_q          <= '0;
            first_err_pos_q <= '0;
            err_cnt_q       <= '0;
`endif
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            c_q       <= c_d;
            k_q       <= k_d;
            i_q       <= i_d;
            sr_q      <= sr_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            done_q    <= done_d;
            n_out_q   <= n_out_d;
            match_q   <= match_d;
            err_len_q <= err_len_d;
`ifdef PATDEC_ERRPOS_EN
            fe_q            <= fe_d;
            fe_vld_q        <= fe_vld_d;
            ecnt_q          <= ecnt_d;
            first_err_pos_q <= first_err_pos_d;
            err_cnt_q       <= err_cnt_d;
`endif
        end
    end

    assign busy    = (state_q == RUN) || (state_q == CHECK);
    assign done    = done_q;
    assign n_out   = n_out_q;
    assign match   = match_q;
    assign err_len = err_len_q;
`ifdef PATDEC_ERRPOS_EN
    assign first_err_pos = first_err_pos_q;
    assign err_cnt       = err_cnt_q;
`endif

endmodule

// File: tb/tb_pattern_decode.sv
// tb_pattern_decode: table-driven, hand-written and randomized checks of pattern_decode
// against an even-spread reference model (ones at positions floor(i*M/N)).
module tb_pattern_decode;

    localparam int CNT_W   = 5;
    localparam int MAX_LEN = 16;
    localparam int NONE    = 31;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] M = '0;
    logic             bit_vld = 1'b0;
    logic             bit_in = 1'b0;
    logic             busy, done, match, err_len;
    logic [CNT_W-1:0] n_out;
`ifdef PATDEC_ERRPOS_EN
    logic [CNT_W-1:0] first_err_pos, err_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pattern_decode #(.CNT_W(CNT_W), .MAX_LEN(MAX_LEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .M       (M),
        .bit_vld (bit_vld),
        .bit_in  (bit_in),
        .busy    (busy),
        .done    (done),
        .n_out   (n_out),
        .match   (match),
        .err_len (err_len)
`ifdef PATDEC_ERRPOS_EN
        ,
        .first_err_pos (first_err_pos),
        .err_cnt       (err_cnt)
`endif
    );

    typedef struct {
        int          m;
        logic [15:0] frame;
        int          gap;
        int          midstart;
        int          en;
        int          emt;
        int          eerr;
        int          efe;
        int          eec;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic fbit(input logic [15:0] f, input int idx);
        logic [31:0] u;
        u = idx;
        return f[u[3:0]];
    endfunction

    // Reference: ones at floor(i*M/N), i = 0..N-1; compare position by position.
    task automatic model(input int m, input logic [15:0] frame,
                         output int n, output int mt, output int err, output int fe, output int ec);
        logic [15:0] expv;
        int pos;
        n = 0; mt = 0; err = 1; fe = NONE; ec = 0;
        if (m == 0 || m > MAX_LEN) return;
        err = 0;
        for (int p = 0; p < m; p++) n += int'(fbit(frame, m - 1 - p));
        expv = '0;
        for (int i = 0; i < n; i++) begin
            pos = (i * m) / n;
            expv[pos[3:0]] = 1'b1;
        end
        mt = 1;
        for (int p = 0; p < m; p++) begin
            if (fbit(expv, p) != fbit(frame, m - 1 - p)) begin
                mt = 0;
                if (fe == NONE) fe = p;
                ec++;
            end
        end
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        int          lat;
        logic        busy_seen;
        logic        busy_all;
        logic [31:0] mu;
        mu = v.m;
        start = 1'b1;
        M = mu[4:0];
        tick;
        if (v.m == 0 || v.m > MAX_LEN) begin
            // start stays high through DONE and must be ignored there
            busy_seen = busy;
            M = 5'd5;
            tick;
            start = 1'b0;
            lat = 1;
            busy_seen |= busy;
            while (!done && lat < 8) begin
                tick;
                lat++;
                busy_seen |= busy;
            end
            check({tag, "_busy"}, busy_seen, 0);
        end else begin
            start = 1'b0;
            busy_all = 1'b1;
            for (int p = 0; p < v.m; p++) begin
                if (p > 0 && ((v.gap > 0 && p % v.gap == 0) ||
                              (v.gap < 0 && $urandom_range(0, 2) == 0))) begin
                    bit_vld = 1'b0;
                    bit_in = 1'($urandom_range(0, 1));
                    tick;
                    busy_all &= busy;
                end
                if (v.midstart != 0 && p == v.m / 2) begin
                    start = 1'b1;
                    M = 5'd3;
                    bit_vld = 1'b0;
                    tick;
                    start = 1'b0;
                    busy_all &= busy;
                end
                bit_vld = 1'b1;
                bit_in = fbit(v.frame, v.m - 1 - p);
                tick;
                busy_all &= busy;
            end
            check({tag, "_busy"}, busy_all, 1);
            lat = 0;
            while (!done && lat < 40) begin
                bit_vld = 1'($urandom_range(0, 1));
                bit_in = 1'($urandom_range(0, 1));
                tick;
                lat++;
            end
            bit_vld = 1'b0;
            lat = lat - v.m;
        end
        check({tag, "_latency"}, lat, 1);
        check({tag, "_done"}, done, 1);
        check({tag, "_n_out"}, n_out, v.en);
        check({tag, "_match"}, match, v.emt);
        check({tag, "_err_len"}, err_len, v.eerr);
`ifdef PATDEC_ERRPOS_EN
        check({tag, "_first_err_pos"}, first_err_pos, v.efe);
        check({tag, "_err_cnt"}, err_cnt, v.eec);
`endif
        tick;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_n_out_held"}, n_out, v.en);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   dcount;
        logic [31:0] mu;

        vecs.push_back('{8,  16'h00A4, 0, 0, 3,  1, 0, NONE, 0});
        vecs.push_back('{16, 16'h8888, 3, 0, 4,  1, 0, NONE, 0});
        vecs.push_back('{8,  16'h00C4, 0, 0, 3,  0, 0, 1,    2});
        vecs.push_back('{5,  16'h001F, 0, 0, 5,  1, 0, NONE, 0});
        vecs.push_back('{5,  16'h0000, 0, 0, 0,  1, 0, NONE, 0});
        vecs.push_back('{0,  16'h0000, 0, 0, 0,  0, 1, NONE, 0});
        vecs.push_back('{17, 16'h0000, 0, 0, 0,  0, 1, NONE, 0});
        vecs.push_back('{31, 16'h0000, 0, 0, 0,  0, 1, NONE, 0});
        vecs.push_back('{1,  16'h0001, 0, 0, 1,  1, 0, NONE, 0});
        vecs.push_back('{1,  16'h0000, 0, 0, 0,  1, 0, NONE, 0});
        vecs.push_back('{16, 16'hFFFF, 0, 0, 16, 1, 0, NONE, 0});
        vecs.push_back('{16, 16'h0001, 0, 0, 1,  0, 0, 0,    2});
        vecs.push_back('{3,  16'h0005, 0, 0, 2,  0, 0, 1,    2});
        vecs.push_back('{8,  16'h00A4, 0, 1, 3,  1, 0, NONE, 0});

        rst = 1'b1;
        tick;
        tick;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_n_out", n_out, 0);
        check("reset_match", match, 0);
        check("reset_err_len", err_len, 0);
`ifdef PATDEC_ERRPOS_EN
        check("reset_first_err_pos", first_err_pos, 0);
        check("reset_err_cnt", err_cnt, 0);
`endif
        rst = 1'b0;
        tick;

        foreach (vecs[j]) run_frame($sformatf("vec%0d", j), vecs[j]);

        // Reset in the middle of a frame: no done for it, next frame clean.
        start = 1'b1;
        M = 5'd16;
        tick;
        start = 1'b0;
        for (int p = 0; p < 7; p++) begin
            bit_vld = 1'b1;
            bit_in = 1'($urandom_range(0, 1));
            tick;
        end
        bit_vld = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_abort_busy", busy, 0);
        check("rst_abort_n_out", n_out, 0);
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            bit_vld = 1'($urandom_range(0, 1));
            bit_in = 1'($urandom_range(0, 1));
            tick;
            dcount += int'(done);
        end
        bit_vld = 1'b0;
        check("rst_abort_no_done", dcount, 0);
        run_frame("after_rst", '{4, 16'h000F, 0, 0, 4, 1, 0, NONE, 0});

        // Randomized frames against the reference model.
        for (int r = 0; r < 40; r++) begin
            int n, pos;
            v.gap = -1;
            v.midstart = 0;
            v.frame = '0;
            if ($urandom_range(0, 9) == 0) begin
                v.m = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 31));
            end else begin
                v.m = int'($urandom_range(1, MAX_LEN));
                if ($urandom_range(0, 1) == 0) begin
                    n = int'($urandom_range(0, v.m));
                    for (int i = 0; i < n; i++) begin
                        pos = v.m - 1 - (i * v.m) / n;
                        v.frame[pos[3:0]] = 1'b1;
                    end
                end else begin
                    mu = $urandom;
                    v.frame = mu[15:0] & 16'((32'h1 << v.m) - 1);
                end
            end
            model(v.m, v.frame, v.en, v.emt, v.eerr, v.efe, v.eec);
            run_frame($sformatf("rand%0d_m%0d", r, v.m), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
